// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - TAP state encoding, instruction codes and DR select type
package jtag_pkg;

    typedef enum logic [3:0] {
        TAP_EX2_DR     = 4'h0,
        TAP_EX1_DR     = 4'h1,
        TAP_SHIFT_DR   = 4'h2,
        TAP_PAUSE_DR   = 4'h3,
        TAP_SELECT_IR  = 4'h4,
        TAP_UPDATE_DR  = 4'h5,
        TAP_CAPTURE_DR = 4'h6,
        TAP_SELECT_DR  = 4'h7,
        TAP_EX2_IR     = 4'h8,
        TAP_EX1_IR     = 4'h9,
        TAP_SHIFT_IR   = 4'hA,
        TAP_PAUSE_IR   = 4'hB,
        TAP_RTI        = 4'hC,
        TAP_UPDATE_IR  = 4'hD,
        TAP_CAPTURE_IR = 4'hE,
        TAP_TLR        = 4'hF
    } tap_state_t;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_t;

    localparam logic [3:0] INSN_IDCODE = 4'b0001;
    localparam logic [3:0] INSN_USER   = 4'b1000;
    localparam logic [3:0] INSN_BYPASS = 4'b1111;
    localparam logic [3:0] IR_CAPTURE  = 4'b0101;

endpackage

// File: rtl/jtag_tap_if.sv
// rtl/jtag_tap_if.sv - JTAG pin bundle between a tester/wrapper and the TAP
interface jtag_tap_if;
    logic tck;
    logic tms;
    logic tdi;
    logic tdo;
    logic tdo_oe;

    modport master (
        output tck,
        output tms,
        output tdi,
        input  tdo,
        input  tdo_oe
    );

    modport slave (
        input  tck,
        input  tms,
        input  tdi,
        output tdo,
        output tdo_oe
    );
endinterface

// File: rtl/jtag_sync.sv
// rtl/jtag_sync.sv - pin synchronisers and TCK edge strobes in the clk domain
module jtag_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic tck,
    input  logic tms,
    input  logic tdi,
    output logic tck_rise,
    output logic tck_fall,
    output logic tms_s,
    output logic tdi_s
);
    logic [2:0] tck_q;
    logic [1:0] tms_q;
    logic [1:0] tdi_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tck_q <= '0;
            tms_q <= '0;
            tdi_q <= '0;
        end else begin
            tck_q <= {tck_q[1:0], tck};
            tms_q <= {tms_q[0], tms};
            tdi_q <= {tdi_q[0], tdi};
        end
    end

    // Both strobes come from the same flop pair, so they can never coincide.
    assign tck_rise = tck_q[1] & ~tck_q[2];
    assign tck_fall = ~tck_q[1] & tck_q[2];
    assign tms_s    = tms_q[1];
    assign tdi_s    = tdi_q[1];
endmodule

// File: rtl/jtag_tap.sv
// rtl/jtag_tap.sv - oversampled 1149.1 TAP with IR, IDCODE, BYPASS and USER DR
module jtag_tap
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'hDEC0_DE01,
    parameter int          USER_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    jtag_tap_if.slave             jtag,
    output logic [3:0]            tap_state,
    output logic [IR_WIDTH-1:0]   ir_q,
    input  logic [USER_WIDTH-1:0] user_in,
    output logic [USER_WIDTH-1:0] user_out,
    output logic                  user_update
);
    logic tck_rise;
    logic tck_fall;
    logic tms_s;
    logic tdi_s;

    tap_state_t state_q;
    tap_state_t state_d;

    logic [IR_WIDTH-1:0]   ir_sr;
    logic [31:0]           idcode_sr;
    logic [USER_WIDTH-1:0] user_sr;
    logic                  bypass_sr;
    logic                  tdo_q;
    dr_sel_t               dr_sel;
    logic                  dr_lsb;

    jtag_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .tck      (jtag.tck),
        .tms      (jtag.tms),
        .tdi      (jtag.tdi),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall),
        .tms_s    (tms_s),
        .tdi_s    (tdi_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= TAP_TLR;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tck_rise) begin
            case (state_q)
                TAP_TLR:        state_d = tms_s ? TAP_TLR       : TAP_RTI;
                TAP_RTI:        state_d = tms_s ? TAP_SELECT_DR : TAP_RTI;
                TAP_SELECT_DR:  state_d = tms_s ? TAP_SELECT_IR : TAP_CAPTURE_DR;
                TAP_CAPTURE_DR: state_d = tms_s ? TAP_EX1_DR    : TAP_SHIFT_DR;
                TAP_SHIFT_DR:   state_d = tms_s ? TAP_EX1_DR    : TAP_SHIFT_DR;
                TAP_EX1_DR:     state_d = tms_s ? TAP_UPDATE_DR : TAP_PAUSE_DR;
                TAP_PAUSE_DR:   state_d = tms_s ? TAP_EX2_DR    : TAP_PAUSE_DR;
                TAP_EX2_DR:     state_d = tms_s ? TAP_UPDATE_DR : TAP_SHIFT_DR;
                TAP_UPDATE_DR:  state_d = tms_s ? TAP_SELECT_DR : TAP_RTI;
                TAP_SELECT_IR:  state_d = tms_s ? TAP_TLR       : TAP_CAPTURE_IR;
                TAP_CAPTURE_IR: state_d = tms_s ? TAP_EX1_IR    : TAP_SHIFT_IR;
                TAP_SHIFT_IR:   state_d = tms_s ? TAP_EX1_IR    : TAP_SHIFT_IR;
                TAP_EX1_IR:     state_d = tms_s ? TAP_UPDATE_IR : TAP_PAUSE_IR;
                TAP_PAUSE_IR:   state_d = tms_s ? TAP_EX2_IR    : TAP_PAUSE_IR;
                TAP_EX2_IR:     state_d = tms_s ? TAP_UPDATE_IR : TAP_SHIFT_IR;
                TAP_UPDATE_IR:  state_d = tms_s ? TAP_SELECT_DR : TAP_RTI;
                default:        state_d = TAP_TLR;
            endcase
        end
    end

    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_q == IR_WIDTH'(INSN_IDCODE))    dr_sel = DR_IDCODE;
        else if (ir_q == IR_WIDTH'(INSN_USER)) dr_sel = DR_USER;
    end

    always_comb begin
        dr_lsb = bypass_sr;
        case (dr_sel)
            DR_IDCODE: dr_lsb = idcode_sr[0];
            DR_USER:   dr_lsb = user_sr[0];
            default:   dr_lsb = bypass_sr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir_sr       <= '0;
            ir_q        <= IR_WIDTH'(INSN_IDCODE);
            idcode_sr   <= '0;
            user_sr     <= '0;
            bypass_sr   <= 1'b0;
            user_out    <= '0;
            user_update <= 1'b0;
            tdo_q       <= 1'b0;
        end else begin
            user_update <= 1'b0;
            if (tck_rise) begin
                // Actions belong to the state being left, i.e. state_q.
                case (state_q)
                    TAP_CAPTURE_IR: ir_sr <= IR_WIDTH'(IR_CAPTURE);
                    TAP_SHIFT_IR:   ir_sr <= {tdi_s, ir_sr[IR_WIDTH-1:1]};
                    TAP_UPDATE_IR:  ir_q  <= ir_sr;
                    TAP_CAPTURE_DR: begin
                        case (dr_sel)
                            DR_IDCODE: idcode_sr <= IDCODE_VAL;
                            DR_USER:   user_sr   <= user_in;
                            default:   bypass_sr <= 1'b0;
                        endcase
                    end
                    TAP_SHIFT_DR: begin
                        case (dr_sel)
                            DR_IDCODE: idcode_sr <= {tdi_s, idcode_sr[31:1]};
                            DR_USER:   user_sr   <= {tdi_s, user_sr[USER_WIDTH-1:1]};
                            default:   bypass_sr <= tdi_s;
                        endcase
                    end
                    TAP_UPDATE_DR: begin
                        if (dr_sel == DR_USER) begin
                            user_out    <= user_sr;
                            user_update <= 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (state_d == TAP_TLR) ir_q <= IR_WIDTH'(INSN_IDCODE);
            end
            if (tck_fall) begin
                if (state_q == TAP_SHIFT_IR)      tdo_q <= ir_sr[0];
                else if (state_q == TAP_SHIFT_DR) tdo_q <= dr_lsb;
            end
        end
    end

    assign tap_state   = state_q;
    assign jtag.tdo    = tdo_q;
    assign jtag.tdo_oe = (state_q == TAP_SHIFT_IR) || (state_q == TAP_SHIFT_DR);
endmodule

// File: tb/tb_jtag_tap.sv
// tb/tb_jtag_tap.sv - table-driven TCK-cycle vectors plus reset corner sequences
module tb_jtag_tap;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] tap_state;
    logic [3:0] ir_q;
    logic [7:0] user_in = 8'h00;
    logic [7:0] user_out;
    logic       user_update;

    jtag_tap_if jif ();

    jtag_tap #(.IR_WIDTH(4), .IDCODE_VAL(32'hDEC0_DE01), .USER_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .jtag        (jif.slave),
        .tap_state   (tap_state),
        .ir_q        (ir_q),
        .user_in     (user_in),
        .user_out    (user_out),
        .user_update (user_update)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       tms;
        logic       tdi;
        logic       chk_tdo;
        logic       exp_tdo;
        logic       exp_oe;
        logic [3:0] exp_state;
        logic [3:0] exp_ir;
    } vec_t;

    vec_t       vq[$];
    logic [3:0] prev_state = 4'hF;
    int         n_vec = 0;
    int         n_err = 0;
    int         upd_cnt = 0;

    logic [31:0] idv  = 32'hDEC0_DE01;
    logic [3:0]  capv = 4'b0101;
    logic [7:0]  a5   = 8'hA5;
    logic [7:0]  c3   = 8'hC3;
    logic [7:0]  h3c  = 8'h3C;
    logic [3:0]  usr  = 4'b1000;

    always @(posedge clk) if (user_update === 1'b1) upd_cnt <= upd_cnt + 1;

    function automatic void add(input logic tms, input logic tdi, input logic chk,
                                input logic tdo, input logic [3:0] st, input logic [3:0] ir);
        vec_t v;
        v.tms = tms; v.tdi = tdi; v.chk_tdo = chk; v.exp_tdo = tdo;
        v.exp_oe = (prev_state == 4'hA) || (prev_state == 4'h2);
        v.exp_state = st; v.exp_ir = ir;
        vq.push_back(v);
        prev_state = st;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One TCK period: low phase, sample pins before the rise, high phase, then fall.
    task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v,
                             output logic oe_v, output logic [3:0] st_v, output logic [3:0] ir_v);
        @(negedge clk);
        jif.tms = tms_v;
        jif.tdi = tdi_v;
        repeat (5) @(negedge clk);
        tdo_v = jif.tdo;
        oe_v  = jif.tdo_oe;
        jif.tck = 1'b1;
        repeat (6) @(negedge clk);
        st_v = tap_state;
        ir_v = ir_q;
        jif.tck = 1'b0;
    endtask

    initial begin
        logic       t_tdo, t_oe;
        logic [3:0] t_st, t_ir;

        jif.tck = 1'b0; jif.tms = 1'b1; jif.tdi = 1'b0;
        user_in = 8'h3C;

        // IDCODE readout
        add(0,0,0,0,4'hC,4'h1); add(1,0,0,0,4'h7,4'h1);
        add(0,0,0,0,4'h6,4'h1); add(0,0,0,0,4'h2,4'h1);
        for (int i = 0; i < 32; i++)
            add(i == 31, 0, 1, idv[i], (i == 31) ? 4'h1 : 4'h2, 4'h1);
        add(1,0,0,0,4'h5,4'h1); add(0,0,0,0,4'hC,4'h1);
        // IR <- BYPASS, capture pattern visible on tdo
        add(1,0,0,0,4'h7,4'h1); add(1,0,0,0,4'h4,4'h1);
        add(0,0,0,0,4'hE,4'h1); add(0,0,0,0,4'hA,4'h1);
        for (int i = 0; i < 4; i++)
            add(i == 3, 1, 1, capv[i], (i == 3) ? 4'h9 : 4'hA, 4'h1);
        add(1,0,0,0,4'hD,4'h1); add(0,0,0,0,4'hC,4'hF);
        // BYPASS delays by one TCK
        add(1,0,0,0,4'h7,4'hF); add(0,0,0,0,4'h6,4'hF); add(0,0,0,0,4'h2,4'hF);
        for (int j = 0; j < 9; j++)
            add(j == 8, (j < 8) ? a5[j] : 1'b0, 1, (j == 0) ? 1'b0 : a5[j-1],
                (j == 8) ? 4'h1 : 4'h2, 4'hF);
        add(1,0,0,0,4'h5,4'hF); add(0,0,0,0,4'hC,4'hF);
        // IR <- USER, capture 3C, shift in C3, update
        add(1,0,0,0,4'h7,4'hF); add(1,0,0,0,4'h4,4'hF);
        add(0,0,0,0,4'hE,4'hF); add(0,0,0,0,4'hA,4'hF);
        for (int i = 0; i < 4; i++)
            add(i == 3, usr[i], 1, capv[i], (i == 3) ? 4'h9 : 4'hA, 4'hF);
        add(1,0,0,0,4'hD,4'hF); add(0,0,0,0,4'hC,4'h8);
        add(1,0,0,0,4'h7,4'h8); add(0,0,0,0,4'h6,4'h8); add(0,0,0,0,4'h2,4'h8);
        for (int i = 0; i < 8; i++)
            add(i == 7, c3[i], 1, h3c[i], (i == 7) ? 4'h1 : 4'h2, 4'h8);
        add(1,0,0,0,4'h5,4'h8); add(0,0,0,0,4'hC,4'h8);
        // Five TMS=1 from Shift-IR; Update-IR briefly loads 0010 on the way
        add(1,0,0,0,4'h7,4'h8); add(1,0,0,0,4'h4,4'h8);
        add(0,0,0,0,4'hE,4'h8); add(0,0,0,0,4'hA,4'h8);
        add(1,0,1,1,4'h9,4'h8); add(1,0,0,0,4'hD,4'h8);
        add(1,0,0,0,4'h7,4'h2); add(1,0,0,0,4'h4,4'h2); add(1,0,0,0,4'hF,4'h1);
        // Set up a USER Shift-DR for the reset-abort sequence
        add(0,0,0,0,4'hC,4'h1); add(1,0,0,0,4'h7,4'h1); add(1,0,0,0,4'h4,4'h1);
        add(0,0,0,0,4'hE,4'h1); add(0,0,0,0,4'hA,4'h1);
        for (int i = 0; i < 4; i++)
            add(i == 3, usr[i], 1, capv[i], (i == 3) ? 4'h9 : 4'hA, 4'h1);
        add(1,0,0,0,4'hD,4'h1); add(0,0,0,0,4'hC,4'h8);
        add(1,0,0,0,4'h7,4'h8); add(0,0,0,0,4'h6,4'h8); add(0,0,0,0,4'h2,4'h8);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_state",  {28'd0, tap_state}, 32'hF);
        check("rst_ir",     {28'd0, ir_q}, 32'h1);
        check("rst_oe",     {31'd0, jif.tdo_oe}, 32'h0);
        check("rst_tdo",    {31'd0, jif.tdo}, 32'h0);
        check("rst_user",   {24'd0, user_out}, 32'h0);
        check("rst_upd",    {31'd0, user_update}, 32'h0);

        foreach (vq[k]) begin
            tck_cycle(vq[k].tms, vq[k].tdi, t_tdo, t_oe, t_st, t_ir);
            check($sformatf("v%0d_oe", k), {31'd0, t_oe}, {31'd0, vq[k].exp_oe});
            if (vq[k].chk_tdo)
                check($sformatf("v%0d_tdo", k), {31'd0, t_tdo}, {31'd0, vq[k].exp_tdo});
            check($sformatf("v%0d_state", k), {28'd0, t_st}, {28'd0, vq[k].exp_state});
            check($sformatf("v%0d_ir", k), {28'd0, t_ir}, {28'd0, vq[k].exp_ir});
        end

        check("user_update_cycles", upd_cnt, 1);
        check("user_out_c3", {24'd0, user_out}, 32'hC3);

        // Three shifts into the USER DR, then reset mid-shift
        for (int i = 0; i < 3; i++) begin
            tck_cycle(1'b0, 1'b1, t_tdo, t_oe, t_st, t_ir);
            check($sformatf("abort_tdo%0d", i), {31'd0, t_tdo}, {31'd0, h3c[i]});
            check($sformatf("abort_state%0d", i), {28'd0, t_st}, 32'h2);
        end
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_state", {28'd0, tap_state}, 32'hF);
        check("abort_ir",    {28'd0, ir_q}, 32'h1);
        check("abort_user",  {24'd0, user_out}, 32'h0);
        check("abort_oe",    {31'd0, jif.tdo_oe}, 32'h0);
        check("abort_tdo",   {31'd0, jif.tdo}, 32'h0);
        repeat (10) @(negedge clk);
        check("abort_no_update", upd_cnt, 1);
        tck_cycle(1'b1, 1'b0, t_tdo, t_oe, t_st, t_ir);
        check("tlr_hold", {28'd0, t_st}, 32'hF);
        tck_cycle(1'b0, 1'b0, t_tdo, t_oe, t_st, t_ir);
        check("tlr_to_rti", {28'd0, t_st}, 32'hC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/jtag_tap.md
# jtag_tap

Oversampled IEEE 1149.1 TAP controller sitting directly behind the top-level pin mapping of `tt_um_jtag_example_stevej`: the wrapper routes TCK/TMS/TDI from `ui_in` into this block and drives TDO back out. It synchronises the JTAG pins into the system clock domain and runs the 16-state TAP FSM. It implements the IR, IDCODE, BYPASS and an 8-bit USER data register.

## Interface
Parameters:
- `IR_WIDTH`, 4, instruction register width.
- `IDCODE_VAL`, 32'hDEC0_DE01, value captured by IDCODE; bit 0 must be 1.
- `USER_WIDTH`, 8, width of the USER data register.

Ports:
- `clk`  in  1  system clock; the only clock in the block.
- `rst_n`  in  1  reset, synchronous, active-low.
- `tck`  in  1  JTAG clock, asynchronous to `clk`; treated as data.
- `tms`  in  1  JTAG mode select, asynchronous.
- `tdi`  in  1  JTAG serial in, asynchronous.
- `tdo`  out  1  JTAG serial out.
- `tdo_oe`  out  1  high while in Shift-IR or Shift-DR.
- `tap_state`  out  4  current TAP state encoding.
- `ir_q`  out  IR_WIDTH  active instruction.
- `user_in`  in  USER_WIDTH  parallel value captured by USER in Capture-DR.
- `user_out`  out  USER_WIDTH  parallel value loaded by USER in Update-DR.
- `user_update`  out  1  one-`clk` pulse when `user_out` is loaded.

## Operation
- `tck`, `tms` and `tdi` each pass through a 2-flop synchroniser. A third `tck` flop provides edge detection, giving `tck_rise` and `tck_fall` one-`clk` strobes.
- On `tck_rise`:
  - The FSM advances per the standard 1149.1 transition graph using synchronised `tms`.
  - The action of the state being left is performed:
    - Capture-IR loads 4'b0101 into the IR shift register.
    - Capture-DR loads the selected DR.
    - Shift-IR and Shift-DR shift right, with `tdi` entering the MSB.
    - Update-IR copies the IR shift register to `ir_q`.
    - Update-DR with USER selected copies to `user_out` and pulses `user_update`.
- On `tck_fall`: `tdo` is loaded with the LSB of the active shift register when in Shift-IR or Shift-DR; otherwise `tdo` holds. `tdo_oe` follows the state combinationally.
- Instruction decode:
  - 4'b0001 selects IDCODE (32 bits).
  - 4'b1000 selects USER (USER_WIDTH bits).
  - 4'b1111 and all other codes select BYPASS (1 bit, captures 0).
- Entering Test-Logic-Reset, whether by TMS-high sequence or `rst_n`, sets `ir_q` to IDCODE. `user_out` is cleared only by `rst_n`.
- Five consecutive `tck` rises with `tms`=1 reach Test-Logic-Reset from any state.

## Timing
- Reset: `rst_n` sampled low on a `clk` rising edge sets the following:
  - `tap_state` = Test-Logic-Reset (4'hF).
  - `ir_q` = 4'b0001.
  - `tdo` = 0, `tdo_oe` = 0.
  - `user_out` = 0, `user_update` = 0.
  - All synchronisers and shift registers cleared.
- Reset mid-shift aborts the operation. No Update occurs.
- Pin-to-action latency: a `tck` edge at the pin produces its strobe 3 `clk` cycles later. The FSM and registers change on the following `clk` edge.
- `tdo` is valid 4 `clk` cycles after the pin-level falling `tck` edge.
- TCK high and low phases must each last ≥ 4 `clk` periods. `tms`/`tdi` must be stable ≥ 4 `clk` before and 1 `clk` after the pin-level rising `tck`. Faster TCK is unsupported; behaviour is then undefined, but the FSM must stay in a legal state.
- `user_update` is high for exactly one `clk`, in the cycle after the `tck_rise` that leaves Update-DR.
- `tck_rise` and `tck_fall` are never simultaneous, because both derive from one edge detector.

## Structure
- Package `jtag_pkg`:
  - `tap_state_t`, a 4-bit enum using the standard encoding (TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D).
  - Instruction constants `INSN_IDCODE`, `INSN_USER`, `INSN_BYPASS`.
  - Capture constant `IR_CAPTURE`.
- One sub-module, `jtag_sync`: the 2-flop synchroniser plus edge detector for `tck`, with pass-through synchronisers for `tms`/`tdi`.

## Test plan
- Hold `rst_n` low for 2 `clk`, then release -> `tap_state`=4'hF, `ir_q`=4'b0001, `tdo_oe`=0, `user_out`=8'h00.
- From reset, TMS sequence 0,1,0,0 to reach Shift-DR, then 32 shifts -> `tdo` serialises 32'hDEC0_DE01 LSB first; `tdo_oe`=1 only during shifts.
- Load IR 4'b1111, then shift 8'hA5 through DR -> `tdo` reproduces the pattern delayed by exactly 1 TCK. Shifting out IR during this load returns 4'b0101.
- Load IR 4'b1000 with `user_in`=8'h3C, capture and shift in 8'hC3, then Update-DR -> `tdo` emits 8'h3C, `user_out`=8'hC3, and `user_update` pulses for one `clk`.
- From Shift-IR, five TCKs with `tms`=1 -> Test-Logic-Reset, `ir_q`=4'b0001, `user_out` unchanged.
- Assert `rst_n` in the middle of a USER Shift-DR -> immediate TLR, `user_out`=0, and no `user_update` pulse.
